// File: rtl/ghost_mode_scheduler_pkg.sv
// Shared types and constants for the ghost release / scatter-chase / fright scheduler.
package ghost_sched_pkg;

   localparam int CNT_W          = 10;
   localparam int SCATTER_PHASES = 4;
   localparam int PHASE_W        = 3;

   // Phase index after the last scatter phase has completed: chase forever.
   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(2 * SCATTER_PHASES - 1);

   typedef enum logic {
      SCATTER = 1'b0,
      CHASE   = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FROZEN
   } state_t;

   function automatic logic [CNT_W-1:0] to_cnt(input int frames);
      return CNT_W'(frames);
   endfunction

   // Even phases are scatter, odd phases are chase.
   function automatic mode_t phase_mode(input logic [PHASE_W-1:0] phase);
      return mode_t'(phase[0]);
   endfunction

endpackage

// File: rtl/ghost_mode_scheduler_frame_timer.sv
// Frame-paced down-counter: loads a length, counts frames to zero, flags the expiring frame.
module frame_timer
   import ghost_sched_pkg::*;
(
   input  logic             clk,
   input  logic             resetN,
   input  logic             start_of_frame,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             zero,
   output logic             expire
);

   logic [CNT_W-1:0] count_next;

   assign zero   = (count == '0);
   // High in the cycle whose frame tick takes the counter from 1 to 0.
   assign expire = enable && start_of_frame && (count == CNT_W'(1));

   // NOTE: count_next gets its default first so every path assigns it and no latch is inferred.
   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (load)
         count_next = load_value;
      else if (enable && start_of_frame && !zero)
         count_next = count - 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Frame-driven controller for the four ghosts: staggered release, scatter/chase schedule,
// frightened overlay after power pellets and respawn delay for eaten ghosts.
module ghost_mode_scheduler
   import ghost_sched_pkg::*;
#(
   parameter int RELEASE_GAP_FRAMES = 90,
   parameter int RESPAWN_FRAMES     = 150,
   parameter int FRIGHT_FRAMES      = 180,
   parameter int BLINK_FRAMES       = 60,
   parameter int SCATTER_FRAMES     = 210,
   parameter int CHASE_FRAMES       = 600
)(
   input  logic       clk,
   input  logic       resetN,
   input  logic       start_of_frame,
   input  logic       game_started,
   input  logic       pm_lost_life,
   input  logic       is_pm_alive,
   input  logic       power_pellet,
   input  logic [3:0] ghost_eaten,
   output logic [3:0] ghost_alive,
   output logic       ghost_mode,
   output logic [3:0] frightened,
   output logic       fright_ending,
   output logic       reverse_pulse
);

   localparam int T_REL    = 0;
   localparam int T_PH     = 1;
   localparam int T_FR     = 2;
   localparam int T_RS     = 3;
   localparam int N_TIMERS = 7;

   state_t             state, state_next;
   mode_t              mode, mode_next;
   logic [PHASE_W-1:0] phase, phase_next;
   logic [3:0]         released, released_next;
   logic [3:0]         alive_next, fright_next;
   logic               rev_next;
   logic               active;

   logic [N_TIMERS-1:0] t_clear, t_load, t_en, t_expire;
   logic [CNT_W-1:0]    t_load_val [N_TIMERS];
   logic [CNT_W-1:0]    t_count    [N_TIMERS];
   logic                t_zero     [N_TIMERS];
   logic [CNT_W-1:0]    ph_load_val;

   // Timer 0: release, 1: scatter/chase phase, 2: fright, 3..6: respawn per ghost.
   for (genvar k = 0; k < N_TIMERS; k++) begin : g_timer
      frame_timer u_timer (
         .clk            (clk),
         .resetN         (resetN),
         .start_of_frame (start_of_frame),
         .clear          (t_clear[k]),
         .load           (t_load[k]),
         .load_value     (t_load_val[k]),
         .enable         (t_en[k]),
         .count          (t_count[k]),
         .zero           (t_zero[k]),
         .expire         (t_expire[k])
      );
   end

   always_comb begin
      t_load_val[T_REL] = to_cnt(RELEASE_GAP_FRAMES);
      t_load_val[T_PH]  = ph_load_val;
      t_load_val[T_FR]  = to_cnt(FRIGHT_FRAMES);
      for (int i = 0; i < 4; i++)
         t_load_val[T_RS+i] = to_cnt(RESPAWN_FRAMES);
   end

   // Timers only advance while playing, Pac-Man alive, and no life-loss restart pending.
   assign active = (state != ST_IDLE) && is_pm_alive && !pm_lost_life;

   always_comb begin
      state_next    = state;
      mode_next     = mode;
      phase_next    = phase;
      released_next = released;
      alive_next    = ghost_alive;
      fright_next   = frightened;
      rev_next      = 1'b0;
      ph_load_val   = to_cnt(SCATTER_FRAMES);
      t_clear       = '0;
      t_load        = '0;
      t_en          = {N_TIMERS{active}};
      t_en[T_PH]    = active && (frightened == 4'b0000);

      if (pm_lost_life) begin
         state_next    = ST_IDLE;
         mode_next     = SCATTER;
         phase_next    = '0;
         released_next = '0;
         alive_next    = '0;
         fright_next   = '0;
         t_clear       = '1;
      end else if (!is_pm_alive) begin
         if (state == ST_RUN)
            state_next = ST_FROZEN;
      end else if (state == ST_IDLE) begin
         if (game_started) begin
            state_next    = ST_RUN;
            released_next = 4'b0001;
            alive_next    = 4'b0001;
            t_load[T_REL] = 1'b1;
            t_load[T_PH]  = 1'b1;
         end
      end else begin
         state_next = ST_RUN;

         // The pellet re-frightens only ghosts alive before this edge, so a ghost
         // released, revived or eaten in the same cycle ends up non-frightened.
         if (power_pellet) begin
            fright_next  = ghost_alive;
            t_load[T_FR] = 1'b1;
            rev_next     = 1'b1;
         end else if (t_expire[T_FR]) begin
            fright_next = '0;
         end

         if (t_expire[T_PH]) begin
            // NOTE: blocking assignment inside always_comb lets phase_next be reused below.
            phase_next   = phase + 1'b1;
            mode_next    = phase_mode(phase_next);
            rev_next     = 1'b1;
            t_load[T_PH] = (phase_next != LAST_PHASE);
            ph_load_val  = (mode_next == CHASE) ? to_cnt(CHASE_FRAMES) : to_cnt(SCATTER_FRAMES);
         end

         if (t_expire[T_REL]) begin
            released_next = {released[2:0], 1'b1};
            alive_next    = alive_next | (released_next & ~released);
            t_load[T_REL] = !released[2];
         end

         for (int i = 0; i < 4; i++) begin
            if (ghost_eaten[i] && frightened[i]) begin
               alive_next[i]    = 1'b0;
               fright_next[i]   = 1'b0;
               t_load[T_RS+i]   = 1'b1;
            end else if (t_expire[T_RS+i]) begin
               alive_next[i]  = 1'b1;
               fright_next[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state         <= ST_IDLE;
         mode          <= SCATTER;
         phase         <= '0;
         released      <= '0;
         ghost_alive   <= '0;
         frightened    <= '0;
         reverse_pulse <= 1'b0;
      end else begin
         state         <= state_next;
         mode          <= mode_next;
         phase         <= phase_next;
         released      <= released_next;
         ghost_alive   <= alive_next;
         frightened    <= fright_next;
         reverse_pulse <= rev_next;
      end
   end

   assign ghost_mode    = mode;
   // Decoded purely from registered state: blink during the last BLINK_FRAMES of fright.
   assign fright_ending = (t_count[T_FR] <= to_cnt(BLINK_FRAMES)) && !t_zero[T_FR] && (|frightened);

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Scoreboard bench: a frame-counting reference model predicts outputs; a monitor compares each cycle.
module tb_ghost_mode_scheduler;

   localparam int GAP    = 4;
   localparam int RESP   = 3;
   localparam int FRIGHT = 6;
   localparam int BLINK  = 2;
   localparam int SCAT   = 5;
   localparam int CHS    = 8;

   logic       clk = 1'b0;
   logic       resetN, sof, gs, lost, pma, pel;
   logic [3:0] eaten;
   logic [3:0] alive, fr;
   logic       mode, fe, rev;

   ghost_mode_scheduler #(
      .RELEASE_GAP_FRAMES (GAP),
      .RESPAWN_FRAMES     (RESP),
      .FRIGHT_FRAMES      (FRIGHT),
      .BLINK_FRAMES       (BLINK),
      .SCATTER_FRAMES     (SCAT),
      .CHASE_FRAMES       (CHS)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .start_of_frame (sof),
      .game_started   (gs),
      .pm_lost_life   (lost),
      .is_pm_alive    (pma),
      .power_pellet   (pel),
      .ghost_eaten    (eaten),
      .ghost_alive    (alive),
      .ghost_mode     (mode),
      .frightened     (fr),
      .fright_ending  (fe),
      .reverse_pulse  (rev)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] alive;
      logic       mode;
      logic [3:0] fr;
      logic       fe;
      logic       rev;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc_n = 0;

   // Reference model: frames counted since play began, frames of unfrightened schedule time,
   // frames of fright left and frames each ghost still has to wait before respawning.
   bit         m_play;
   int         m_run, m_sched, m_left;
   int         m_dead [4];
   logic [3:0] m_fr;
   logic       m_rev;

   function automatic logic mode_of(input int t);
      int rem = t;
      for (int p = 0; p < 7; p++) begin
         int len = (p % 2 == 0) ? SCAT : CHS;
         if (rem < len) return logic'(p % 2);
         rem -= len;
      end
      return 1'b1;
   endfunction

   function automatic logic [3:0] cur_alive();
      int         n;
      logic [3:0] rel, dm;
      if (!m_play) return 4'b0000;
      n   = 1 + ((m_run / GAP > 3) ? 3 : m_run / GAP);
      rel = 4'((1 << n) - 1);
      for (int i = 0; i < 4; i++) dm[i] = (m_dead[i] != 0);
      return rel & ~dm;
   endfunction

   function automatic void model_clear();
      m_run = 0; m_sched = 0; m_left = 0; m_fr = 4'b0000;
      for (int i = 0; i < 4; i++) m_dead[i] = 0;
   endfunction

   function automatic void model_step();
      logic [3:0] old_alive, new_fr;
      logic       old_mode;
      m_rev = 1'b0;
      if (!resetN || lost) begin
         m_play = 1'b0;
         model_clear();
      end else if (!pma) begin
         // frozen: nothing moves
      end else if (!m_play) begin
         if (gs) begin
            m_play = 1'b1;
            model_clear();
         end
      end else begin
         old_alive = cur_alive();
         old_mode  = mode_of(m_sched);
         new_fr    = m_fr;
         if (pel) begin
            new_fr = old_alive;
            m_left = FRIGHT;
         end else if (sof && m_left > 0) begin
            m_left--;
            if (m_left == 0) new_fr = 4'b0000;
         end
         for (int i = 0; i < 4; i++) begin
            if (eaten[i] && m_fr[i]) begin
               m_dead[i] = RESP;
               new_fr[i] = 1'b0;
            end else if (sof && m_dead[i] > 0) begin
               m_dead[i]--;
            end
         end
         if (sof && m_fr == 4'b0000) m_sched++;
         if (sof) m_run++;
         m_fr  = new_fr;
         m_rev = pel || (mode_of(m_sched) != old_mode);
      end
   endfunction

   function automatic exp_t expected();
      exp_t e;
      e.alive = cur_alive();
      e.mode  = mode_of(m_sched);
      e.fr    = m_fr;
      e.fe    = (m_left >= 1) && (m_left <= BLINK) && (m_fr != 4'b0000);
      e.rev   = m_rev;
      return e;
   endfunction

   task automatic check(input exp_t e);
      exp_t got;
      got = '{alive: alive, mode: mode, fr: fr, fe: fe, rev: rev};
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL outputs@cyc%0d: got alive=%b mode=%b fr=%b fe=%b rev=%b, want alive=%b mode=%b fr=%b fe=%b rev=%b",
                  cyc_n, got.alive, got.mode, got.fr, got.fe, got.rev,
                  e.alive, e.mode, e.fr, e.fe, e.rev);
      end
   endtask

   // Monitor: compares the registered outputs shortly after every active edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cyc_n++;
            check(e);
         end
      end
   end

   task automatic cyc(input logic s, input logic p, input logic l, input logic [3:0] e);
      sof   = s;
      pel   = p;
      lost  = l;
      eaten = e;
      model_step();
      exp_q.push_back(expected());
      @(negedge clk);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         cyc(1'b1, 1'b0, 1'b0, 4'b0000);
         cyc(1'b0, 1'b0, 1'b0, 4'b0000);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end, want end of stimulus");
      $fatal(1);
   end

   initial begin
      resetN = 1'b0; sof = 1'b0; gs = 1'b0; lost = 1'b0;
      pma = 1'b1; pel = 1'b0; eaten = 4'b0000;
      model_clear();
      m_play = 1'b0;
      @(negedge clk);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'b0000);
      resetN = 1'b1;

      // Idle without a game: frame ticks and pellets do nothing.
      frames(2);
      cyc(1'b0, 1'b1, 1'b0, 4'b0000);

      // Start: staggered release and the full scatter/chase schedule.
      gs = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 4'b0000);
      frames(50);

      // Single pellet with everyone out, then a pellet extended by a second one.
      cyc(1'b0, 1'b1, 1'b0, 4'b0000);
      frames(7);
      cyc(1'b0, 1'b1, 1'b0, 4'b0000);
      frames(3);
      cyc(1'b0, 1'b1, 1'b0, 4'b0000);
      frames(10);

      // Eat a frightened ghost, watch it respawn; eating unfrightened ghosts is ignored.
      cyc(1'b0, 1'b1, 1'b0, 4'b0000);
      frames(1);
      cyc(1'b0, 1'b0, 1'b0, 4'b0100);
      frames(4);
      frames(3);
      cyc(1'b0, 1'b0, 1'b0, 4'b1111);
      frames(2);

      // Life loss with game_started held: one idle cycle, then release restarts.
      cyc(1'b0, 1'b0, 1'b1, 4'b0000);
      frames(3);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      frames(2);

      // Freeze mid-release for 20 frames, then restart from the frozen state.
      pma = 1'b0;
      frames(20);
      gs = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 4'b0000);
      pma = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 4'b0000);
      gs = 1'b1;
      frames(14);

      // Randomized play.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) pma = ~pma;
         if (!pma && $urandom_range(0, 29) == 0) pma = 1'b1;
         if ($urandom_range(0, 299) == 0) gs = ~gs;
         if (!gs && $urandom_range(0, 9) == 0) gs = 1'b1;
         cyc(logic'($urandom_range(0, 2) == 0),
             logic'($urandom_range(0, 59) == 0),
             logic'($urandom_range(0, 699) == 0),
             ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000);
      end
      cyc(1'b0, 1'b0, 1'b0, 4'b0000);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ghost_mode_scheduler.md
# ghost_mode_scheduler

Frame-driven controller for the four ghost movers. It sequences the staggered release of ghosts from the chamber after game start or a life loss, and runs the global scatter/chase schedule. It handles the frightened overlay after a power pellet and enforces respawn delays for eaten ghosts. Its `ghost_alive[i]` outputs drive each ghost motion block's `is_alive`. Its mode outputs feed the ghost target/direction logic.

## Interface
- `RELEASE_GAP_FRAMES`, 90: frames between consecutive ghost releases.
- `RESPAWN_FRAMES`, 150: frames an eaten ghost stays dead.
- `FRIGHT_FRAMES`, 180: frightened duration after a power pellet.
- `BLINK_FRAMES`, 60: final portion of frightened time flagged for blinking; must be ≤ `FRIGHT_FRAMES`.
- `SCATTER_FRAMES`, 210: length of each scatter phase.
- `CHASE_FRAMES`, 600: length of each chase phase. All frame parameters are in 1..1023.
- `clk`, in, 1: clock.
- `resetN`, in, 1: reset, asynchronous, active-low.
- `start_of_frame`, in, 1: one-cycle pulse per frame (30 Hz).
- `game_started`, in, 1: level; high while play is enabled.
- `pm_lost_life`, in, 1: one-cycle pulse; restarts the sequence.
- `is_pm_alive`, in, 1: level; low freezes the scheduler.
- `power_pellet`, in, 1: one-cycle pulse.
- `ghost_eaten`, in, 4: per-ghost one-cycle pulse on collision.
- `ghost_alive`, out, 4: per-ghost alive/released.
- `ghost_mode`, out, 1: 0 = SCATTER, 1 = CHASE.
- `frightened`, out, 4: per-ghost frightened flag.
- `fright_ending`, out, 1: blink flag.
- `reverse_pulse`, out, 1: one-cycle pulse commanding all ghosts to reverse.

## Operation
- **Top FSM states:** IDLE, RUN, FROZEN.
- **Reset and IDLE values:** `ghost_alive=0000`, `ghost_mode=SCATTER`, `frightened=0000`, `fright_ending=0`, `reverse_pulse=0`. All counters are cleared.
- **IDLE → RUN** when `game_started=1`. On entry, `ghost_alive[0]` is set and the release counter loads `RELEASE_GAP_FRAMES`.
- **Release:** in RUN, the release counter decrements on each `start_of_frame`.
  - When it reaches 0, the lowest unreleased ghost index is set alive and the counter reloads.
  - After ghost 3 is released, the release counter stops.
- **Scatter/chase schedule:** a phase index (3 bits) and a phase timer run in RUN.
  - The timer decrements on `start_of_frame` only while `frightened==0000`.
  - Phases alternate SCATTER/CHASE starting with SCATTER; each phase lasts its parameter length.
  - After the 4th SCATTER phase completes, `ghost_mode` stays CHASE permanently for the rest of the life.
  - Every mode flip asserts `reverse_pulse` for one cycle.
- **Power pellet:**
  - `frightened <= ghost_alive`; the fright timer loads `FRIGHT_FRAMES`.
  - `reverse_pulse` is asserted for one cycle.
  - A pellet during frightened time reloads the timer and re-frightens every alive ghost.
- **Fright timer:**
  - Decrements on `start_of_frame`.
  - `fright_ending = (timer ≤ BLINK_FRAMES) && (timer ≠ 0) && |frightened`.
  - When the timer reaches 0, `frightened` is cleared.
- **Ghost eaten:**
  - If `ghost_eaten[i]` arrives while `frightened[i]=1`: `ghost_alive[i] <= 0`, `frightened[i] <= 0`, and respawn counter i loads `RESPAWN_FRAMES`.
  - Respawn counter i decrements on `start_of_frame`; at 0, `ghost_alive[i] <= 1` with `frightened[i]=0`.
  - `ghost_eaten[i]` while not frightened is ignored.
- **Pac-Man death:** `is_pm_alive=0` → FROZEN. All counters and outputs hold, and no events are accepted.
- **Life loss:** `pm_lost_life` → IDLE from any state, and all outputs take their IDLE values.
- **Input priority:** `pm_lost_life` > `!is_pm_alive` > other events.
- **Simultaneous events in one cycle:**
  - `ghost_eaten[i]` with `power_pellet`: ghost i goes dead and is not frightened.
  - Respawn reaching 0 with `power_pellet`: ghost revives non-frightened.
  - Release with `power_pellet`: the newly released ghost is not frightened.
  - Mode flip with `power_pellet`: a single `reverse_pulse`.

## Timing
- All outputs are registered. An input event is visible on outputs one clock after the sampling edge.
- Frame timers change only in cycles where `start_of_frame=1`.
- Entering RUN with `game_started` high in the cycle after `pm_lost_life` costs exactly one IDLE cycle.
- Counters are 10 bits unsigned with no wrap: a counter at 0 never decrements.
- Releases are exactly `RELEASE_GAP_FRAMES` frames apart: ghost k becomes alive on the k·`RELEASE_GAP_FRAMES`-th `start_of_frame` after entering RUN.

## Structure
- Shared package `ghost_sched_pkg`: mode enum (SCATTER, CHASE), top-state enum, the phase count constant (4 scatter phases), and the counter width (10).
- Sub-module `frame_timer`: a load/enable down-counter with a `zero` flag that decrements on `start_of_frame`. It is instantiated for release, the phase timer, the fright timer, and four respawn timers.

## Test plan
- Use bench parameters RELEASE_GAP=4, SCATTER=5, CHASE=8, FRIGHT=6, BLINK=2, RESPAWN=3.
- **Staggered release:** reset, then raise `game_started` → `ghost_alive` goes 0001, then 0011, 0111, 1111 at frames 4, 8 and 12.
- **Schedule:** no pellets → `ghost_mode` flips at frames 5, 13, 18, 26, 31, 39, 44, and stays CHASE after frame 44. A `reverse_pulse` occurs at each flip.
- **Frightened:** pellet with all alive → `frightened=1111` and the schedule pauses. `fright_ending` is high for frames 4–5, and everything clears at frame 6. A second pellet at frame 3 extends the clear to frame 9.
- **Eat ghost:** `ghost_eaten=0100` while frightened → `ghost_alive=1011`, `frightened[2]=0`. Ghost 2 revives 3 frames later non-frightened. `ghost_eaten` while not frightened → no change.
- **Freeze and restart:** drop `is_pm_alive` mid-release → outputs hold for 20 frames. Then pulse `pm_lost_life` → all outputs return to their IDLE values next cycle, and release restarts from ghost 0.
